// File: rtl/serv_mem_dpath_pkg.sv
// Shared encodings for the SERV load/store data path.
package serv_mem_dpath_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Size code 2'b11 behaves as a word, so any size with bit 1 set needs lsb == 0.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    return ((size == SZ_HALF) & lsb[0]) | (size[1] & (|lsb));
  endfunction

endpackage

// File: rtl/serv_mem_align.sv
// Byte-lane logic shared by stores and loads: lane enables, store data
// replication and load alignment with sign/zero extension.
module serv_mem_align
  import serv_mem_dpath_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lsb,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  // Narrow the aligned lane down to the access size and fill the upper bits.
  function automatic logic [31:0] extend(input logic [31:0] lane,
                                         input logic [1:0]  sz,
                                         input logic        sgn);
    logic [31:0] res;
    case (sz)
      SZ_BYTE: res = {{24{sgn & lane[7]}}, lane[7:0]};
      SZ_HALF: res = {{16{sgn & lane[15]}}, lane[15:0]};
      default: res = lane;
    endcase
    return res;
  endfunction

  logic [31:0] lane;

  // Lane selection, replication and extension are purely combinational.
  always_comb begin
    sel       = 4'b1111;
    wdata_rep = wdata;
    lane      = rdata >> {lsb, 3'b000};
    case (size)
      SZ_BYTE: begin
        sel       = 4'b0001 << lsb;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        sel       = lsb[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
    rdata_ext = extend(lane, size, sign_ext);
  end

endmodule

// File: rtl/serv_mem_dpath.sv
// Load/store data path for the bit-serial SERV core: fills a store word from
// rs2 beats, runs one bus cycle, and streams aligned load data back to rd.
module serv_mem_dpath
  import serv_mem_dpath_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 4,
  // Derived from BITS_PER_CYCLE; not meant to be overridden.
  parameter int LB = $clog2(BITS_PER_CYCLE)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic                      i_cmd,
  input  logic [1:0]                i_size,
  input  logic                      i_signed,
  input  logic [1:0]                i_lsb,
  input  logic                      i_start,
  input  logic [BITS_PER_CYCLE-1:0] i_rs2,
  output logic [BITS_PER_CYCLE-1:0] o_rd,
  output logic                      o_rd_valid,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_misalign,
  output logic                      o_dbus_cyc,
  output logic                      o_dbus_we,
  output logic [3:0]                o_dbus_sel,
  output logic [31:0]               o_dbus_dat,
  input  logic [31:0]               i_dbus_rdt,
  input  logic                      i_dbus_ack
);

  localparam int W  = BITS_PER_CYCLE;
  localparam int CW = 5 - LB;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic [31:0]    data;
  logic           done;
  logic [3:0]     sel;
  logic [31:0]    wdata_rep;
  logic [31:0]    rdata_ext;

  logic in_req;
  logic in_drain;
  logic last_beat;

  assign in_req    = (state == ST_REQ);
  assign in_drain  = (state == ST_DRAIN);
  assign last_beat = &cnt;

  serv_mem_align u_align (
    .size      (i_size),
    .lsb       (i_lsb),
    .sign_ext  (i_signed),
    .wdata     (data),
    .rdata     (i_dbus_rdt),
    .sel       (sel),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: a misaligned start never leaves IDLE; acks outside REQ fall through.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (i_start & ~o_misalign) state_nxt = ST_REQ;
      ST_REQ:   if (i_dbus_ack) state_nxt = i_cmd ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: if (i_en & last_beat) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Completion pulse, one cycle after the store ack or the final load beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) done <= 1'b0;
    else       done <= (in_req & i_dbus_ack & i_cmd) | (in_drain & i_en & last_beat);
  end

  // Data register doubles as store collector and load shifter; the beat counter wraps on the last beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (i_en & i_cmd) data <= {i_rs2, data[31:W]};
        ST_REQ:   if (i_dbus_ack & ~i_cmd) data <= rdata_ext;
        ST_DRAIN: if (i_en) begin
          data <= {{W{1'b0}}, data[31:W]};
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_done     = done;
  assign o_busy     = (state != ST_IDLE);
  assign o_misalign = misaligned(i_size, i_lsb);
  assign o_dbus_cyc = in_req;
  assign o_dbus_we  = in_req & i_cmd;
  assign o_dbus_sel = in_req ? sel : 4'b0000;
  assign o_dbus_dat = in_req ? wdata_rep : 32'h0;
  assign o_rd_valid = in_drain & i_en;
  assign o_rd       = o_rd_valid ? data[W-1:0] : '0;

endmodule

// File: tb/tb_serv_mem_dpath.sv
// Self-checking bench: three data paths (W = 1, 2, 4) share the control
// inputs; only the selected one receives i_en and is observed.
module tb_serv_mem_dpath;

  logic        clk;
  logic        rst, en, cmd, sgn, start, ack;
  logic [1:0]  size, lsb;
  logic [3:0]  rs2;
  logic [31:0] rdt;
  int          cur;          // 0 -> W=1, 1 -> W=2, 2 -> W=4
  int          checks = 0;
  int          errors = 0;

  wire [0:0]        rd1;
  wire [1:0]        rd2;
  wire [3:0]        rd4;
  wire [2:0]        vld, busy, done, mis, cyc, we;
  wire [2:0][3:0]   bsel;
  wire [2:0][31:0]  dat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serv_mem_dpath #(.BITS_PER_CYCLE(1)) u_w1 (
    .i_clk(clk), .i_rst(rst), .i_en(en && (cur == 0)), .i_cmd(cmd), .i_size(size),
    .i_signed(sgn), .i_lsb(lsb), .i_start(start), .i_rs2(rs2[0:0]), .o_rd(rd1),
    .o_rd_valid(vld[0]), .o_busy(busy[0]), .o_done(done[0]), .o_misalign(mis[0]),
    .o_dbus_cyc(cyc[0]), .o_dbus_we(we[0]), .o_dbus_sel(bsel[0]), .o_dbus_dat(dat[0]),
    .i_dbus_rdt(rdt), .i_dbus_ack(ack));

  serv_mem_dpath #(.BITS_PER_CYCLE(2)) u_w2 (
    .i_clk(clk), .i_rst(rst), .i_en(en && (cur == 1)), .i_cmd(cmd), .i_size(size),
    .i_signed(sgn), .i_lsb(lsb), .i_start(start), .i_rs2(rs2[1:0]), .o_rd(rd2),
    .o_rd_valid(vld[1]), .o_busy(busy[1]), .o_done(done[1]), .o_misalign(mis[1]),
    .o_dbus_cyc(cyc[1]), .o_dbus_we(we[1]), .o_dbus_sel(bsel[1]), .o_dbus_dat(dat[1]),
    .i_dbus_rdt(rdt), .i_dbus_ack(ack));

  serv_mem_dpath #(.BITS_PER_CYCLE(4)) u_w4 (
    .i_clk(clk), .i_rst(rst), .i_en(en && (cur == 2)), .i_cmd(cmd), .i_size(size),
    .i_signed(sgn), .i_lsb(lsb), .i_start(start), .i_rs2(rs2), .o_rd(rd4),
    .o_rd_valid(vld[2]), .o_busy(busy[2]), .o_done(done[2]), .o_misalign(mis[2]),
    .o_dbus_cyc(cyc[2]), .o_dbus_we(we[2]), .o_dbus_sel(bsel[2]), .o_dbus_dat(dat[2]),
    .i_dbus_rdt(rdt), .i_dbus_ack(ack));

  // ---------------- behavioural reference ----------------
  function automatic int bw(); return 1 << cur; endfunction

  function automatic logic [3:0] cur_rd();
    case (cur)
      0:       return {3'b000, rd1};
      1:       return {2'b00, rd2};
      default: return rd4;
    endcase
  endfunction

  function automatic logic [31:0] m_load(int sz, int ls, bit s, logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * ls);
    if (sz == 0) begin
      v = v % 256;
      if (s && v >= 128) v = v - 256;
    end else if (sz == 1) begin
      v = v % 65536;
      if (s && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_sel(int sz, int ls);
    if (sz == 0) return 4'(1 << ls);
    if (sz == 1) return (ls >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_dat(int sz, logic [31:0] v);
    if (sz == 0) return (v % 256) * 32'h01010101;
    if (sz == 1) return (v % 65536) * 32'h00010001;
    return v;
  endfunction

  function automatic bit m_mis(int sz, int ls);
    return (sz == 1 && (ls % 2) == 1) || (sz >= 2 && ls != 0);
  endfunction

  function automatic int aligned_lsb(int sz);
    if (sz == 0) return $urandom_range(3, 0);
    if (sz == 1) return 2 * $urandom_range(1, 0);
    return 0;
  endfunction

  // ---------------- scenario tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; start = 1'b0; ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_store(int sz, int ls, logic [31:0] val, int extra, int wt);
    int w, nb;
    logic [31:0] mask;
    w = bw(); nb = 32 / w; mask = (32'h1 << w) - 1;
    cmd = 1'b1; size = 2'(sz); lsb = 2'(ls);
    for (int i = 0; i < extra + nb; i++) begin
      @(negedge clk);
      en  = 1'b1;
      rs2 = (i < extra) ? 4'($urandom) : 4'((val >> ((i - extra) * w)) & mask);
    end
    @(negedge clk);
    en = 1'b0; start = 1'b1;
    #1;
    checks++;
    if (busy[cur] !== 1'b0) begin errors++; $display("FAIL st_idle_busy: got %b want 0", busy[cur]); end
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= wt; c++) begin
      if (c != 0) @(negedge clk);
      ack = (c == wt); en = 1'($urandom); rs2 = 4'($urandom); rdt = $urandom;
      #1;
      checks++;
      if (cyc[cur] !== 1'b1 || we[cur] !== 1'b1 || done[cur] !== 1'b0) begin
        errors++; $display("FAIL st_req_ctl: cyc=%b we=%b done=%b want 1 1 0", cyc[cur], we[cur], done[cur]);
      end
      checks++;
      if (bsel[cur] !== m_sel(sz, ls)) begin errors++; $display("FAIL st_sel: got %b want %b", bsel[cur], m_sel(sz, ls)); end
      checks++;
      if (dat[cur] !== m_dat(sz, val)) begin errors++; $display("FAIL st_dat: got %h want %h", dat[cur], m_dat(sz, val)); end
    end
    @(negedge clk);
    ack = 1'b0; en = 1'b0;
    #1;
    checks++;
    if (done[cur] !== 1'b1 || cyc[cur] !== 1'b0 || busy[cur] !== 1'b0 || dat[cur] !== 32'h0) begin
      errors++; $display("FAIL st_done: done=%b cyc=%b busy=%b dat=%h want 1 0 0 0", done[cur], cyc[cur], busy[cur], dat[cur]);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done[cur] !== 1'b0) begin errors++; $display("FAIL st_done_pulse: got %b want 0", done[cur]); end
  endtask

  task automatic do_load(int sz, int ls, bit s, logic [31:0] word, int wt, bit gapped);
    int w, nb, beat, c;
    logic [31:0] mask, exp, got;
    w = bw(); nb = 32 / w; mask = (32'h1 << w) - 1;
    exp = m_load(sz, ls, s, word); got = '0;
    cmd = 1'b0; size = 2'(sz); lsb = 2'(ls); sgn = s; en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= wt; k++) begin
      if (k != 0) @(negedge clk);
      ack = (k == wt); rdt = (k == wt) ? word : $urandom; en = 1'($urandom);
      #1;
      checks++;
      if (cyc[cur] !== 1'b1 || we[cur] !== 1'b0 || bsel[cur] !== m_sel(sz, ls)) begin
        errors++; $display("FAIL ld_req: cyc=%b we=%b sel=%b want 1 0 %b", cyc[cur], we[cur], bsel[cur], m_sel(sz, ls));
      end
    end
    @(negedge clk);
    ack = 1'b0; rdt = $urandom;
    beat = 0; c = 0;
    while (beat < nb) begin
      en = gapped ? 1'(c % 2) : 1'b1;
      start = 1'($urandom);
      #1;
      checks++;
      if (busy[cur] !== 1'b1 || done[cur] !== 1'b0 || cyc[cur] !== 1'b0) begin
        errors++; $display("FAIL ld_drain_ctl: busy=%b done=%b cyc=%b want 1 0 0", busy[cur], done[cur], cyc[cur]);
      end
      checks++;
      if (en) begin
        if (vld[cur] !== 1'b1 || cur_rd() !== 4'((exp >> (beat * w)) & mask)) begin
          errors++; $display("FAIL ld_beat%0d: vld=%b rd=%h want 1 %h", beat, vld[cur], cur_rd(), 4'((exp >> (beat * w)) & mask));
        end
        got = got | ((32'(cur_rd()) & mask) << (beat * w));
        beat++;
      end else if (vld[cur] !== 1'b0 || cur_rd() !== 4'h0) begin
        errors++; $display("FAIL ld_gap: vld=%b rd=%h want 0 0", vld[cur], cur_rd());
      end
      c++;
      @(negedge clk);
    end
    en = 1'b0; start = 1'b0;
    #1;
    checks++;
    if (done[cur] !== 1'b1 || busy[cur] !== 1'b0 || vld[cur] !== 1'b0) begin
      errors++; $display("FAIL ld_done: done=%b busy=%b vld=%b want 1 0 0", done[cur], busy[cur], vld[cur]);
    end
    checks++;
    if (got !== exp) begin errors++; $display("FAIL ld_word: got %h want %h", got, exp); end
    @(negedge clk);
    #1;
    checks++;
    if (done[cur] !== 1'b0) begin errors++; $display("FAIL ld_done_pulse: got %b want 0", done[cur]); end
  endtask

  task automatic test_reset();
    cur = 2; cmd = 1'b0; sgn = 1'b0; size = 2'b00; lsb = 2'b00; rs2 = '0; rdt = '0;
    do_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (busy[k] !== 1'b0 || done[k] !== 1'b0 || cyc[k] !== 1'b0 || we[k] !== 1'b0 ||
          bsel[k] !== 4'h0 || dat[k] !== 32'h0 || vld[k] !== 1'b0) begin
        errors++; $display("FAIL reset_w%0d: busy=%b done=%b cyc=%b we=%b sel=%b dat=%h vld=%b want all 0",
                           1 << k, busy[k], done[k], cyc[k], we[k], bsel[k], dat[k], vld[k]);
      end
    end
    checks++;
    if (rd1 !== 1'b0 || rd2 !== 2'b00 || rd4 !== 4'h0) begin
      errors++; $display("FAIL reset_rd: got %b %b %h want 0", rd1, rd2, rd4);
    end
  endtask

  task automatic test_store_load();
    do_store(2, 0, 32'hDEADBEEF, 0, 2);
    do_store(0, 3, 32'h0000005A, 2, 1);
    do_store(1, 2, 32'h00001234, 0, 0);
    do_load(0, 1, 1'b1, 32'h0000F000, 1, 1'b0);
    do_load(0, 1, 1'b0, 32'h0000F000, 0, 1'b0);
    do_load(1, 2, 1'b1, 32'h8001ABCD, 0, 1'b0);
    do_load(3, 0, 1'b1, 32'h87654321, 2, 1'b0);
  endtask

  task automatic test_misalign();
    for (int s = 0; s < 4; s++) begin
      for (int l = 0; l < 4; l++) begin
        size = 2'(s); lsb = 2'(l);
        #1;
        checks++;
        if (mis[cur] !== m_mis(s, l)) begin errors++; $display("FAIL misalign_s%0d_l%0d: got %b want %b", s, l, mis[cur], m_mis(s, l)); end
      end
    end
    for (int t = 0; t < 2; t++) begin
      size = (t == 0) ? 2'b01 : 2'b10; lsb = (t == 0) ? 2'b01 : 2'b10; cmd = 1'(t);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 4; c++) begin
        #1;
        checks++;
        if (cyc[cur] !== 1'b0 || busy[cur] !== 1'b0 || done[cur] !== 1'b0) begin
          errors++; $display("FAIL misalign_start: cyc=%b busy=%b done=%b want 0 0 0", cyc[cur], busy[cur], done[cur]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid();
    cmd = 1'b0; size = 2'b10; lsb = 2'b00;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (cyc[cur] !== 1'b1) begin errors++; $display("FAIL rstmid_req: cyc=%b want 1", cyc[cur]); end
    rst = 1'b1; ack = 1'b1; rdt = $urandom;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (cyc[cur] !== 1'b0 || busy[cur] !== 1'b0 || done[cur] !== 1'b0) begin
      errors++; $display("FAIL rstmid_after: cyc=%b busy=%b done=%b want 0 0 0", cyc[cur], busy[cur], done[cur]);
    end
    @(negedge clk);
    ack = 1'b0; en = 1'b1;
    #1;
    checks++;
    if (busy[cur] !== 1'b0 || done[cur] !== 1'b0 || vld[cur] !== 1'b0) begin
      errors++; $display("FAIL rstmid_late_ack: busy=%b done=%b vld=%b want 0 0 0", busy[cur], done[cur], vld[cur]);
    end
    en = 1'b0;
    do_store(2, 0, 32'hCAFEF00D, 0, 1);
  endtask

  task automatic test_stray_ack();
    cmd = 1'b1;
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    #1;
    checks++;
    if (busy[cur] !== 1'b0 || done[cur] !== 1'b0 || cyc[cur] !== 1'b0) begin
      errors++; $display("FAIL stray_ack: busy=%b done=%b cyc=%b want 0 0 0", busy[cur], done[cur], cyc[cur]);
    end
  endtask

  task automatic test_random(int n, bit gapped);
    int sz, ls;
    for (int i = 0; i < n; i++) begin
      sz = $urandom_range(3, 0);
      ls = aligned_lsb(sz);
      if ($urandom_range(1, 0) == 1) do_store(sz, ls, $urandom, $urandom_range(2, 0), $urandom_range(3, 0));
      else do_load(sz, ls, 1'($urandom), $urandom, $urandom_range(3, 0), gapped | 1'($urandom));
    end
  endtask

  task automatic test_widths();
    for (int k = 0; k < 3; k++) begin
      do_reset();
      cur = k;
      do_load(2, 0, 1'b1, 32'h9ABC_DEF1, 1, 1'b1);
      do_load(0, 1, 1'b1, 32'h0000F000, 0, 1'b1);
      do_store(2, 0, 32'hDEADBEEF, 1, 0);
      test_random(4, 1'b1);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; cmd = 1'b0; sgn = 1'b0; start = 1'b0; ack = 1'b0;
    size = 2'b00; lsb = 2'b00; rs2 = '0; rdt = '0; cur = 2;
    test_reset();
    test_store_load();
    test_misalign();
    test_reset_mid();
    test_stray_ack();
    test_random(20, 1'b0);
    test_widths();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
